// File: rtl/seq_detector.sv
// Serial 1011 pattern detector (overlapping) with registered match pulse
// and a saturating match counter.
module seq_detector #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_vld,
    input  logic             clr,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic [2:0]       state_o
);

    localparam logic [2:0] S0    = 3'd0;
    localparam logic [2:0] S1    = 3'd1;
    localparam logic [2:0] S10   = 3'd2;
    localparam logic [2:0] S101  = 3'd3;
    localparam logic [2:0] S1011 = 3'd4;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [2:0]       state;
    logic [2:0]       state_nx;
    logic             match_nx;
    logic [CNT_W-1:0] cnt_nx;

    // State, pulse and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S0;
            match     <= 1'b0;
            match_cnt <= '0;
        end else begin
            state     <= state_nx;
            match     <= match_nx;
            match_cnt <= cnt_nx;
        end
    end

    assign state_o = state;

    // Next state, pulse and count; clear dominates, illegal states recover to S0
    always_comb begin
        state_nx = state;
        match_nx = 1'b0;
        cnt_nx   = match_cnt;
        if (clr) begin
            state_nx = S0;
            cnt_nx   = '0;
        end else if (din_vld) begin
            case (state)
                S0:      state_nx = din ? S1    : S0;
                S1:      state_nx = din ? S1    : S10;
                S10:     state_nx = din ? S101  : S0;
                S101:    state_nx = din ? S1011 : S10;
                S1011:   state_nx = din ? S1    : S10;
                default: state_nx = S0;
            endcase
            if (state == S101 && din) begin
                match_nx = 1'b1;
                if (match_cnt != CNT_MAX) begin
                    cnt_nx = match_cnt + CNT_W'(1);
                end
            end
        end else if (state > S1011) begin
            state_nx = S0;
        end
    end

endmodule

// File: tb/tb_seq_detector.sv
// Randomized and directed bench for seq_detector, checked against a
// suffix-matching reference model of the 1011 pattern.
module tb_seq_detector;

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic       din_vld;
    logic       clr;
    logic       match8;
    logic [7:0] cnt8;
    logic [2:0] state8;
    logic       match2;
    logic [1:0] cnt2;
    logic [2:0] state2;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: last 4 accepted bits and how many are meaningful
    logic [3:0] hist;
    int         nbits;
    int         exp_state;
    logic       exp_match;
    int         exp_cnt8;
    int         exp_cnt2;

    always #5 clk = ~clk;

    seq_detector #(.CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .clr(clr),
        .match(match8), .match_cnt(cnt8), .state_o(state8)
    );

    seq_detector #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .clr(clr),
        .match(match2), .match_cnt(cnt2), .state_o(state2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist      = 4'b0;
        nbits     = 0;
        exp_state = 0;
        exp_match = 1'b0;
        exp_cnt8  = 0;
        exp_cnt2  = 0;
    endtask

    // State = length of the longest suffix of accepted bits that is a prefix of 1011
    function automatic int suffix_len(input logic [3:0] h, input int n);
        logic [3:0] pat;
        logic [3:0] mask;
        pat = 4'b1011;
        for (int k = 4; k >= 1; k--) begin
            mask = 4'((1 << k) - 1);
            if (n >= k && ((h & mask) == 4'(pat >> (4 - k)))) return k;
        end
        return 0;
    endfunction

    task automatic model_edge(input logic d, input logic v, input logic c);
        if (c) begin
            model_reset();
        end else if (v) begin
            hist      = {hist[2:0], d};
            if (nbits < 4) nbits++;
            exp_state = suffix_len(hist, nbits);
            exp_match = (exp_state == 4);
            if (exp_match) begin
                if (exp_cnt8 < 255) exp_cnt8++;
                if (exp_cnt2 < 3) exp_cnt2++;
            end
        end else begin
            exp_match = 1'b0;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".state8"}, 32'(state8), 32'(exp_state));
        check({tag, ".state2"}, 32'(state2), 32'(exp_state));
        check({tag, ".match8"}, 32'(match8), 32'(exp_match));
        check({tag, ".match2"}, 32'(match2), 32'(exp_match));
        check({tag, ".cnt8"},   32'(cnt8),   32'(exp_cnt8));
        check({tag, ".cnt2"},   32'(cnt2),   32'(exp_cnt2));
    endtask

    task automatic step(input string tag, input logic d, input logic v, input logic c);
        @(negedge clk);
        din     = d;
        din_vld = v;
        clr     = c;
        @(posedge clk);
        model_edge(d, v, c);
        #1;
        compare_all(tag);
    endtask

    task automatic send_bits(input string tag, input logic [3:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(tag, bits[i], 1'b1, 1'b0);
    endtask

    logic [6:0] ovl;
    int         sat_seq [5] = '{1, 2, 3, 3, 3};

    initial begin
        rst     = 1'b0;
        din     = 1'b0;
        din_vld = 1'b0;
        clr     = 1'b0;
        model_reset();
        #3;
        compare_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // Reset mid-pattern: asynchronous, no clock edge needed
        send_bits("pre_rst", 4'b0101, 3);
        check("pre_rst.state", 32'(state8), 32'd3);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        @(negedge clk);
        rst = 1'b1;
        step("post_rst", 1'b1, 1'b1, 1'b0);
        check("post_rst.nomatch", 32'(match8), 32'd0);

        // Basic match
        step("clr", 1'b0, 1'b0, 1'b1);
        send_bits("basic", 4'b1011, 4);
        check("basic.match", 32'(match8), 32'd1);
        check("basic.cnt",   32'(cnt8),   32'd1);
        check("basic.state", 32'(state8), 32'd4);
        step("basic.hold", 1'b1, 1'b0, 1'b0);
        check("basic.pulse_once", 32'(match8), 32'd0);
        check("basic.hold_state", 32'(state8), 32'd4);

        // Overlapping matches
        step("clr", 1'b0, 1'b0, 1'b1);
        ovl = 7'b1011011;
        for (int i = 6; i >= 0; i--) begin
            step("overlap", ovl[i], 1'b1, 1'b0);
            if (i == 3 || i == 0) check("overlap.pulse", 32'(match8), 32'd1);
        end
        check("overlap.cnt", 32'(cnt8), 32'd2);

        // Valid gaps with toggling din
        step("clr", 1'b0, 1'b0, 1'b1);
        for (int i = 3; i >= 0; i--) begin
            step("gap.bit", 4'b1011 >> i & 4'b1 ? 1'b1 : 1'b0, 1'b1, 1'b0);
            for (int g = 0; g < 3; g++) step("gap.idle", 1'(g), 1'b0, 1'b0);
        end
        check("gap.cnt", 32'(cnt8), 32'd1);

        // Saturation of the 2-bit counter
        step("clr", 1'b0, 1'b0, 1'b1);
        for (int s = 0; s < 5; s++) begin
            send_bits("sat", 4'b1011, 4);
            check("sat.pulse", 32'(match2), 32'd1);
            check("sat.cnt2",  32'(cnt2),   32'(sat_seq[s]));
        end

        // Clear colliding with the completing bit
        step("clr", 1'b0, 1'b0, 1'b1);
        send_bits("coll", 4'b0101, 3);
        step("coll", 1'b1, 1'b1, 1'b1);
        check("coll.match", 32'(match8), 32'd0);
        check("coll.cnt",   32'(cnt8),   32'd0);
        check("coll.state", 32'(state8), 32'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step("rand", 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 99) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
